// File: rtl/axo32_insn_decoder.sv
// axo32_insn_decoder
// Registered RV32I base-ISA instruction decoder for the Axolotl32 core.
// The instruction word is decoded combinationally and every output is
// captured on the rising clock edge (one cycle of latency, no enable).
//
// Ports:
//   clk              system clock, outputs update on the rising edge
//   rst              asynchronous active-low reset, clears every output
//   inst[31:0]       instruction word to decode
//   op_valid         legal RV32I encoding
//   op_will_read     LOAD
//   op_will_write    STORE
//   op_uses_alu      OP, OP-IMM, BRANCH, AUIPC
//   op_does_flowctl  JAL, JALR, BRANCH
//   op_is_ecall      ECALL
//   op_is_ebreak     EBREAK
//   op_32bit         inst[1:0] == 2'b11
//   op_is_lui        LUI
//   op_is_auipc      AUIPC
//   op_is_imm        OP-IMM (ALU operand 2 is the immediate)
//   imm[31:0]        sign-extended immediate, zero when not applicable
//   rd_we            destination register written (also for rd = x0)
//   rs1_re / rs2_re  source registers read
//   rd/rs1/rs2       raw register index fields of inst
module axo32_insn_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   output logic        op_valid,
   output logic        op_will_read,
   output logic        op_will_write,
   output logic        op_uses_alu,
   output logic        op_does_flowctl,
   output logic        op_is_ecall,
   output logic        op_is_ebreak,
   output logic        op_32bit,
   output logic        op_is_lui,
   output logic        op_is_auipc,
   output logic        op_is_imm,
   output logic [31:0] imm,
   output logic        rd_we,
   output logic        rs1_re,
   output logic        rs2_re,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2
);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_MISC   = 5'b00011;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [4:0]  opcode_s;
   logic [2:0]  f3_s;
   logic [6:0]  f7_s;
   logic [31:0] imm_i_s;
   logic [31:0] imm_s_s;
   logic [31:0] imm_b_s;
   logic [31:0] imm_u_s;
   logic [31:0] imm_j_s;

   logic        valid_s, will_read_s, will_write_s, uses_alu_s, flowctl_s;
   logic        ecall_s, ebreak_s, is32_s, lui_s, auipc_s, is_imm_s;
   logic        rd_we_s, rs1_re_s, rs2_re_s, legal_s;
   logic [31:0] imm_sel_s;

   logic        valid_r, will_read_r, will_write_r, uses_alu_r, flowctl_r;
   logic        ecall_r, ebreak_r, is32_r, lui_r, auipc_r, is_imm_r;
   logic        rd_we_r, rs1_re_r, rs2_re_r;
   logic [31:0] imm_r;
   logic [4:0]  rd_r, rs1_r, rs2_r;

   assign opcode_s = inst[6:2];
   assign f3_s     = inst[14:12];
   assign f7_s     = inst[31:25];

   assign imm_i_s = {{20{inst[31]}}, inst[31:20]};
   assign imm_s_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u_s = {inst[31:12], 12'h000};
   assign imm_j_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Combinational decode of the current instruction word into flags and immediate.
   always_comb begin
      valid_s      = 1'b0;
      will_read_s  = 1'b0;
      will_write_s = 1'b0;
      uses_alu_s   = 1'b0;
      flowctl_s    = 1'b0;
      ecall_s      = 1'b0;
      ebreak_s     = 1'b0;
      lui_s        = 1'b0;
      auipc_s      = 1'b0;
      is_imm_s     = 1'b0;
      rd_we_s      = 1'b0;
      rs1_re_s     = 1'b0;
      rs2_re_s     = 1'b0;
      legal_s      = 1'b0;
      imm_sel_s    = 32'h0000_0000;
      is32_s       = (inst[1:0] == 2'b11);

      if (is32_s) begin
         case (opcode_s)
            OPC_LUI: begin
               valid_s = 1'b1; lui_s = 1'b1; rd_we_s = 1'b1;
               imm_sel_s = imm_u_s;
            end
            OPC_AUIPC: begin
               valid_s = 1'b1; auipc_s = 1'b1; uses_alu_s = 1'b1; rd_we_s = 1'b1;
               imm_sel_s = imm_u_s;
            end
            OPC_JAL: begin
               valid_s = 1'b1; flowctl_s = 1'b1; rd_we_s = 1'b1;
               imm_sel_s = imm_j_s;
            end
            OPC_JALR: begin
               if (f3_s == 3'b000) begin
                  valid_s = 1'b1; flowctl_s = 1'b1; rd_we_s = 1'b1; rs1_re_s = 1'b1;
                  imm_sel_s = imm_i_s;
               end else begin
                  valid_s = 1'b0;
               end
            end
            OPC_BRANCH: begin
               // f3 = 010/011 are unassigned branch conditions
               if ((f3_s != 3'b010) && (f3_s != 3'b011)) begin
                  valid_s = 1'b1; flowctl_s = 1'b1; uses_alu_s = 1'b1;
                  rs1_re_s = 1'b1; rs2_re_s = 1'b1;
                  imm_sel_s = imm_b_s;
               end else begin
                  valid_s = 1'b0;
               end
            end
            OPC_LOAD: begin
               case (f3_s)
                  3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                     valid_s = 1'b1; will_read_s = 1'b1; rd_we_s = 1'b1; rs1_re_s = 1'b1;
                     imm_sel_s = imm_i_s;
                  end
                  default: valid_s = 1'b0;
               endcase
            end
            OPC_STORE: begin
               case (f3_s)
                  3'b000, 3'b001, 3'b010: begin
                     valid_s = 1'b1; will_write_s = 1'b1; rs1_re_s = 1'b1; rs2_re_s = 1'b1;
                     imm_sel_s = imm_s_s;
                  end
                  default: valid_s = 1'b0;
               endcase
            end
            OPC_OPIMM: begin
               // shift-immediates carry f7 in the upper immediate bits
               case (f3_s)
                  3'b001:  legal_s = (f7_s == F7_BASE);
                  3'b101:  legal_s = (f7_s == F7_BASE) || (f7_s == F7_ALT);
                  default: legal_s = 1'b1;
               endcase
               if (legal_s) begin
                  valid_s = 1'b1; uses_alu_s = 1'b1; is_imm_s = 1'b1;
                  rd_we_s = 1'b1; rs1_re_s = 1'b1;
                  imm_sel_s = imm_i_s;
               end else begin
                  valid_s = 1'b0;
               end
            end
            OPC_OP: begin
               // the alternate f7 only exists for SUB and SRA
               legal_s = (f7_s == F7_BASE) ||
                         ((f7_s == F7_ALT) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
               if (legal_s) begin
                  valid_s = 1'b1; uses_alu_s = 1'b1; rd_we_s = 1'b1;
                  rs1_re_s = 1'b1; rs2_re_s = 1'b1;
               end else begin
                  valid_s = 1'b0;
               end
            end
            OPC_MISC: begin
               valid_s = 1'b1;
            end
            OPC_SYSTEM: begin
               if (inst == 32'h0000_0073) begin
                  valid_s = 1'b1; ecall_s = 1'b1;
               end else if (inst == 32'h0010_0073) begin
                  valid_s = 1'b1; ebreak_s = 1'b1;
               end else begin
                  valid_s = 1'b0;
               end
            end
            default: valid_s = 1'b0;
         endcase
      end else begin
         valid_s = 1'b0;
      end
   end

   // Output register: async clear, otherwise capture the decode every edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r      <= 1'b0;
         will_read_r  <= 1'b0;
         will_write_r <= 1'b0;
         uses_alu_r   <= 1'b0;
         flowctl_r    <= 1'b0;
         ecall_r      <= 1'b0;
         ebreak_r     <= 1'b0;
         is32_r       <= 1'b0;
         lui_r        <= 1'b0;
         auipc_r      <= 1'b0;
         is_imm_r     <= 1'b0;
         rd_we_r      <= 1'b0;
         rs1_re_r     <= 1'b0;
         rs2_re_r     <= 1'b0;
         imm_r        <= 32'h0000_0000;
         rd_r         <= 5'd0;
         rs1_r        <= 5'd0;
         rs2_r        <= 5'd0;
      end else begin
         valid_r      <= valid_s;
         will_read_r  <= will_read_s;
         will_write_r <= will_write_s;
         uses_alu_r   <= uses_alu_s;
         flowctl_r    <= flowctl_s;
         ecall_r      <= ecall_s;
         ebreak_r     <= ebreak_s;
         is32_r       <= is32_s;
         lui_r        <= lui_s;
         auipc_r      <= auipc_s;
         is_imm_r     <= is_imm_s;
         rd_we_r      <= rd_we_s;
         rs1_re_r     <= rs1_re_s;
         rs2_re_r     <= rs2_re_s;
         imm_r        <= imm_sel_s;
         rd_r         <= inst[11:7];
         rs1_r        <= inst[19:15];
         rs2_r        <= inst[24:20];
      end
   end

   assign op_valid        = valid_r;
   assign op_will_read    = will_read_r;
   assign op_will_write   = will_write_r;
   assign op_uses_alu     = uses_alu_r;
   assign op_does_flowctl = flowctl_r;
   assign op_is_ecall     = ecall_r;
   assign op_is_ebreak    = ebreak_r;
   assign op_32bit        = is32_r;
   assign op_is_lui       = lui_r;
   assign op_is_auipc     = auipc_r;
   assign op_is_imm       = is_imm_r;
   assign imm             = imm_r;
   assign rd_we           = rd_we_r;
   assign rs1_re          = rs1_re_r;
   assign rs2_re          = rs2_re_r;
   assign rd              = rd_r;
   assign rs1             = rs1_r;
   assign rs2             = rs2_r;

endmodule

// File: tb/tb_axo32_insn_decoder.sv
// tb_axo32_insn_decoder
// Self-checking bench for axo32_insn_decoder: directed vectors from the
// instruction set rules followed by randomized instruction words, each
// compared against an instruction-class reference model.
module tb_axo32_insn_decoder;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic        op_valid, op_will_read, op_will_write, op_uses_alu, op_does_flowctl;
   logic        op_is_ecall, op_is_ebreak, op_32bit, op_is_lui, op_is_auipc, op_is_imm;
   logic [31:0] imm;
   logic        rd_we, rs1_re, rs2_re;
   logic [4:0]  rd, rs1, rs2;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic valid, rd_mem, wr_mem, alu, flow, ecall, ebreak, b32, lui, auipc, isimm, rdwe, rs1re, rs2re;
   } flags_t;

   typedef enum int {C_BAD, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST,
                     C_OPI, C_OP, C_FENCE, C_ECALL, C_EBREAK} iclass_t;

   axo32_insn_decoder dut (
      .clk(clk), .rst(rst), .inst(inst),
      .op_valid(op_valid), .op_will_read(op_will_read), .op_will_write(op_will_write),
      .op_uses_alu(op_uses_alu), .op_does_flowctl(op_does_flowctl),
      .op_is_ecall(op_is_ecall), .op_is_ebreak(op_is_ebreak), .op_32bit(op_32bit),
      .op_is_lui(op_is_lui), .op_is_auipc(op_is_auipc), .op_is_imm(op_is_imm),
      .imm(imm), .rd_we(rd_we), .rs1_re(rs1_re), .rs2_re(rs2_re),
      .rd(rd), .rs1(rs1), .rs2(rs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Which legal instruction (if any) the word is, from the ISA tables.
   function automatic iclass_t classify(input logic [31:0] i);
      int op, f3, f7;
      op = int'(i[6:2]); f3 = int'(i[14:12]); f7 = int'(i[31:25]);
      if (i[1:0] != 2'b11) return C_BAD;
      if (i == 32'h0000_0073) return C_ECALL;
      if (i == 32'h0010_0073) return C_EBREAK;
      case (op)
         'h0D: return C_LUI;
         'h05: return C_AUIPC;
         'h1B: return C_JAL;
         'h19: return (f3 == 0) ? C_JALR : C_BAD;
         'h18: return (f3 inside {0, 1, 4, 5, 6, 7}) ? C_BR : C_BAD;
         'h00: return (f3 inside {0, 1, 2, 4, 5}) ? C_LD : C_BAD;
         'h08: return (f3 inside {0, 1, 2}) ? C_ST : C_BAD;
         'h04: begin
            if (f3 == 1 && f7 != 0) return C_BAD;
            if (f3 == 5 && !(f7 inside {0, 32})) return C_BAD;
            return C_OPI;
         end
         'h0C: begin
            if (f7 == 0) return C_OP;
            if (f7 == 32 && (f3 inside {0, 5})) return C_OP;
            return C_BAD;
         end
         'h03: return C_FENCE;
         default: return C_BAD;
      endcase
   endfunction

   function automatic flags_t ref_flags(input logic [31:0] i);
      flags_t f;
      f = '0;
      case (classify(i))
         C_LUI:    begin f.valid = 1; f.lui = 1; f.rdwe = 1; end
         C_AUIPC:  begin f.valid = 1; f.auipc = 1; f.alu = 1; f.rdwe = 1; end
         C_JAL:    begin f.valid = 1; f.flow = 1; f.rdwe = 1; end
         C_JALR:   begin f.valid = 1; f.flow = 1; f.rdwe = 1; f.rs1re = 1; end
         C_BR:     begin f.valid = 1; f.flow = 1; f.alu = 1; f.rs1re = 1; f.rs2re = 1; end
         C_LD:     begin f.valid = 1; f.rd_mem = 1; f.rdwe = 1; f.rs1re = 1; end
         C_ST:     begin f.valid = 1; f.wr_mem = 1; f.rs1re = 1; f.rs2re = 1; end
         C_OPI:    begin f.valid = 1; f.alu = 1; f.isimm = 1; f.rdwe = 1; f.rs1re = 1; end
         C_OP:     begin f.valid = 1; f.alu = 1; f.rdwe = 1; f.rs1re = 1; f.rs2re = 1; end
         C_FENCE:  f.valid = 1;
         C_ECALL:  begin f.valid = 1; f.ecall = 1; end
         C_EBREAK: begin f.valid = 1; f.ebreak = 1; end
         default:  f = '0;
      endcase
      f.b32 = (i[1:0] == 2'b11);
      return f;
   endfunction

   // Immediate by arithmetic: arithmetic shifts and masks on the whole word.
   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      logic signed [31:0] s;
      logic [31:0] hi;
      s  = i;
      hi = 32'(s >>> 20);
      case (classify(i))
         C_LUI, C_AUIPC:     return i & 32'hFFFF_F000;
         C_JALR, C_LD, C_OPI: return hi;
         C_ST:  return (hi & 32'hFFFF_FFE0) | 32'(i[11:7]);
         C_BR:  return (i[31] ? 32'hFFFF_F000 : 32'h0) | (32'(i[7]) << 11) |
                       (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
         C_JAL: return (i[31] ? 32'hFFF0_0000 : 32'h0) | (32'(i[19:12]) << 12) |
                       (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
         default: return 32'h0;
      endcase
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input flags_t ef, input logic [31:0] ei,
                                input logic [14:0] er);
      flags_t of;
      of = {op_valid, op_will_read, op_will_write, op_uses_alu, op_does_flowctl,
            op_is_ecall, op_is_ebreak, op_32bit, op_is_lui, op_is_auipc, op_is_imm,
            rd_we, rs1_re, rs2_re};
      cmp({tag, ".flags"}, 32'(of), 32'(ef));
      cmp({tag, ".imm"}, imm, ei);
      cmp({tag, ".regs"}, 32'({rd, rs1, rs2}), 32'(er));
   endtask

   task automatic check_model(input string tag, input logic [31:0] i);
      check_outputs(tag, ref_flags(i), ref_imm(i), {i[11:7], i[19:15], i[24:20]});
   endtask

   // Drive between edges, sample 1 time unit after the capturing edge.
   task automatic apply(input string tag, input logic [31:0] i);
      @(negedge clk);
      inst = i;
      @(posedge clk);
      #1;
      check_model(tag, i);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      logic [4:0]  ops [11];
      int          mode;
      ops = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};
      r = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) return r;
      if (mode == 5) begin
         case ($urandom_range(0, 3))
            0: return 32'h0000_0073;
            1: return 32'h0010_0073;
            2: return 32'h0020_0073;
            default: return {r[31:7], 7'b1110011};
         endcase
      end
      r[6:0] = {ops[$urandom_range(0, 10)], 2'b11};
      case ($urandom_range(0, 2))
         0: r[31:25] = 7'b0000000;
         1: r[31:25] = 7'b0100000;
         default: r[31:25] = r[31:25];
      endcase
      return r;
   endfunction

   initial begin
      rst  = 1'b0;
      inst = 32'h0050_0093;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset_hold", '0, 32'h0, 15'h0);

      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_model("addi_after_reset", 32'h0050_0093);
      cmp("addi.imm_const", imm, 32'h0000_0005);

      apply("lui", 32'h1234_5137);
      cmp("lui.imm_const", imm, 32'h1234_5000);
      apply("beq", 32'hFE20_8EE3);
      cmp("beq.imm_const", imm, 32'hFFFF_FFFC);
      apply("sw", 32'h0051_2423);
      cmp("sw.imm_const", imm, 32'h0000_0008);
      apply("lw", 32'hFFF0_2183);
      cmp("lw.imm_const", imm, 32'hFFFF_FFFF);
      apply("ecall", 32'h0000_0073);
      cmp("ecall.flag_const", 32'({op_is_ecall, op_valid}), 32'h3);
      apply("ebreak", 32'h0010_0073);
      apply("zero_word", 32'h0000_0000);
      apply("slli_bad_f7", 32'h4010_1093);
      cmp("slli_bad.valid_const", 32'(op_valid), 32'h0);
      apply("srai", 32'h4030_5093);
      apply("sub", 32'h4030_80B3);
      apply("sll_alt_bad", 32'h4030_90B3);
      apply("jal_neg", 32'hFF9F_F0EF);
      apply("jalr_bad_f3", 32'h0000_90E7);
      apply("fence", 32'h0FF0_000F);
      apply("auipc", 32'h8000_0297);
      apply("blt_bad_f3", 32'h0020_A063);

      // Asynchronous clear between edges, no clock edge involved.
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_outputs("async_reset", '0, 32'h0, 15'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 600; k++) begin
         apply("rand", rand_inst());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
